// File: rtl/dio_pkg.sv
// Shared types for the per-channel DIO driver: mode encoding and the
// shadow/active channel configuration record.
package dio_pkg;

  localparam int DIO_MODE_W = 3;
  // Widest period any build may use; DIV_W must not exceed this.
  localparam int DIO_PERIOD_MAX_W = 32;

  typedef enum logic [DIO_MODE_W-1:0] {
    DIO_HIZ    = 3'd0,
    DIO_LOW    = 3'd1,
    DIO_HIGH   = 3'd2,
    DIO_TOGGLE = 3'd3,
    DIO_PULSE  = 3'd4
  } dio_mode_e;

  // Mode kept as raw bits so reserved codes 5-7 survive into the channel.
  typedef struct packed {
    logic [DIO_MODE_W-1:0]       mode;
    logic [DIO_PERIOD_MAX_W-1:0] period;
  } dio_cfg_t;

endpackage

// File: rtl/dio_channel.sv
// One DIO channel: active configuration, period counter and registered
// out/oe/pulse_done. A one-cycle apply loads the shadow config and restarts.
//
// state   | meaning
// --------+----------------------------------------------------
// S_HIZ   | not driving (HIZ or a reserved mode code)
// S_LOW   | driving 0
// S_HIGH  | driving 1
// S_TOG   | driving a square wave, inverting every period+1 cycles
// S_PULSE | driving 1 while the pulse counter runs
// S_DONE  | pulse finished, driving 0, counter frozen until next apply
module dio_channel
  import dio_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     apply,
  input  dio_cfg_t cfg_shadow,
  output logic     dio_out,
  output logic     dio_oe,
  output logic     pulse_done
);

  typedef enum logic [2:0] {
    S_HIZ   = 3'd0,
    S_LOW   = 3'd1,
    S_HIGH  = 3'd2,
    S_TOG   = 3'd3,
    S_PULSE = 3'd4,
    S_DONE  = 3'd5
  } ch_state_e;

  ch_state_e                   state_q, state_d;
  logic [DIO_PERIOD_MAX_W-1:0] period_q, period_d;
  logic [DIV_W-1:0]            cnt_q, cnt_d;
  logic                        tog_q, tog_d;
  logic                        out_d, oe_d, done_d;
  logic                        at_end;

  assign at_end = (DIO_PERIOD_MAX_W'(cnt_q) == period_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_HIZ;
      period_q   <= '0;
      cnt_q      <= '0;
      tog_q      <= 1'b0;
      dio_out    <= 1'b0;
      dio_oe     <= 1'b0;
      pulse_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      tog_q      <= tog_d;
      dio_out    <= out_d;
      dio_oe     <= oe_d;
      pulse_done <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    tog_d    = tog_q;
    if (apply) begin
      period_d = cfg_shadow.period;
      cnt_d    = '0;
      tog_d    = 1'b0;
      case (cfg_shadow.mode)
        DIO_LOW:    state_d = S_LOW;
        DIO_HIGH:   state_d = S_HIGH;
        DIO_TOGGLE: state_d = S_TOG;
        DIO_PULSE:  state_d = S_PULSE;
        default:    state_d = S_HIZ;
      endcase
    end else begin
      case (state_q)
        S_TOG: begin
          if (at_end) begin
            cnt_d = '0;
            tog_d = ~tog_q;
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
        S_PULSE: begin
          if (at_end) state_d = S_DONE;
          else        cnt_d   = cnt_q + DIV_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Pad values are decoded from the next state so they land in flops.
  always_comb begin
    oe_d   = (state_d != S_HIZ);
    out_d  = (state_d == S_HIGH) || (state_d == S_PULSE) ||
             ((state_d == S_TOG) && tog_d);
    done_d = (state_d == S_DONE);
  end

endmodule

// File: rtl/dio_channel_ctrl.sv
// Per-channel DIO controller: shadow config registers behind a valid/ready
// port, global commit, pad drivers and input synchroniser. DIO_DEBOUNCE_EN
// adds a DEB_CYC-cycle debounce after the synchroniser.
module dio_channel_ctrl
  import dio_pkg::*;
#(
  parameter  int NUM_CH  = 32,
  parameter  int DIV_W   = 16,
  parameter  int DEB_CYC = 4,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [DIO_MODE_W-1:0] cfg_mode,
  input  logic [DIV_W-1:0]      cfg_period,
  input  logic                  cfg_commit,
  output logic                  cfg_err,
  output logic [NUM_CH-1:0]     dio_out,
  output logic [NUM_CH-1:0]     dio_oe,
  input  logic [NUM_CH-1:0]     dio_in,
  output logic [NUM_CH-1:0]     dio_in_sync,
  output logic [NUM_CH-1:0]     pulse_done
);

  if (NUM_CH < 1 || NUM_CH > 64 || DEB_CYC < 1 || DIV_W < 1 ||
      DIV_W > DIO_PERIOD_MAX_W) begin : g_param_check
    $error("dio_channel_ctrl: parameter out of range");
  end

  logic                ready_q, apply_q, err_q;
  logic                wr_acc, commit_acc, ch_ok;
  dio_cfg_t            shadow_q [NUM_CH];
  logic [NUM_CH-1:0]   sync1_q, sync2_q;

  assign wr_acc     = cfg_valid & ready_q;
  assign commit_acc = cfg_commit & ready_q;
  assign ch_ok      = ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH));
  assign cfg_ready  = ready_q;
  assign cfg_err    = err_q;

  // ready_q drops for the one cycle in which apply_q is copying shadows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      apply_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= ~commit_acc;
      apply_q <= commit_acc;
      err_q   <= wr_acc & ~ch_ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_acc && ch_ok && (cfg_ch == CH_W'(i))) begin
          shadow_q[i] <= '{mode: cfg_mode, period: DIO_PERIOD_MAX_W'(cfg_period)};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= dio_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef DIO_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYC + 1);

  logic [DEB_W-1:0]  deb_cnt_q [NUM_CH];
  logic [NUM_CH-1:0] deb_q;

  // Count consecutive cycles of disagreement; any agreement restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q <= '0;
      for (int i = 0; i < NUM_CH; i++) deb_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (deb_cnt_q[i] == DEB_W'(DEB_CYC - 1)) begin
            deb_q[i]     <= sync2_q[i];
            deb_cnt_q[i] <= '0;
          end else begin
            deb_cnt_q[i] <= deb_cnt_q[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign dio_in_sync = deb_q;
`else
  assign dio_in_sync = sync2_q;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dio_channel #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .apply      (apply_q),
      .cfg_shadow (shadow_q[g]),
      .dio_out    (dio_out[g]),
      .dio_oe     (dio_oe[g]),
      .pulse_done (pulse_done[g])
    );
  end

endmodule

// File: tb/tb_dio_channel_ctrl.sv
// Bench for dio_channel_ctrl: a time-since-commit behavioural model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_dio_channel_ctrl;
  import dio_pkg::*;

  // 24 channels leaves indices 24..31 of the 5-bit channel field invalid.
  localparam int NUM_CH  = 24;
  localparam int DIV_W   = 16;
  localparam int DEB_CYC = 4;
  localparam int CH_W    = 5;
`ifdef DIO_DEBOUNCE_EN
  localparam int IN_LAT  = 2 + DEB_CYC;
  localparam bit GLITCH_SEEN = 1'b0;
`else
  localparam int IN_LAT  = 2;
  localparam bit GLITCH_SEEN = 1'b1;
`endif

  logic                  clk, rst;
  logic                  cfg_valid, cfg_ready, cfg_commit, cfg_err;
  logic [CH_W-1:0]       cfg_ch;
  logic [DIO_MODE_W-1:0] cfg_mode;
  logic [DIV_W-1:0]      cfg_period;
  logic [NUM_CH-1:0]     dio_out, dio_oe, dio_in, dio_in_sync, pulse_done;

  dio_channel_ctrl #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEB_CYC(DEB_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_commit(cfg_commit),
    .cfg_err(cfg_err), .dio_out(dio_out), .dio_oe(dio_oe), .dio_in(dio_in),
    .dio_in_sync(dio_in_sync), .pulse_done(pulse_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit              m_ready = 1'b0, m_apply = 1'b0, m_err = 1'b0;
  int              sh_mode [NUM_CH];
  int              sh_per  [NUM_CH];
  int              ac_mode [NUM_CH];
  int              ac_per  [NUM_CH];
  int              t_apply = 0;
  bit [NUM_CH-1:0] s1 = '0, s2 = '0, m_deb = '0;
  bit [NUM_CH-1:0] hist [DEB_CYC];
  bit              m_wr, m_cm, m_ok, all_diff;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_ready = 0; m_apply = 0; m_err = 0; t_apply = 0;
        s1 = '0; s2 = '0; m_deb = '0;
        for (int i = 0; i < NUM_CH; i++) begin
          sh_mode[i] = 0; sh_per[i] = 0; ac_mode[i] = 0; ac_per[i] = 0;
        end
        for (int k = 0; k < DEB_CYC; k++) hist[k] = '0;
      end else begin
        m_wr = cfg_valid && m_ready;
        m_cm = cfg_commit && m_ready;
        m_ok = (int'(cfg_ch) < NUM_CH);
        if (m_apply) begin
          for (int i = 0; i < NUM_CH; i++) begin
            ac_mode[i] = sh_mode[i]; ac_per[i] = sh_per[i];
          end
          t_apply = 0;
        end else begin
          t_apply++;
        end
        if (m_wr && m_ok) begin
          sh_mode[cfg_ch] = int'(cfg_mode);
          sh_per[cfg_ch]  = int'(cfg_period);
        end
        m_err   = m_wr && !m_ok;
        m_apply = m_cm;
        m_ready = !m_cm;
        // Debounced bit flips once the last DEB_CYC synchronised samples all disagree.
        for (int k = DEB_CYC - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = s2;
        for (int i = 0; i < NUM_CH; i++) begin
          all_diff = 1'b1;
          for (int k = 0; k < DEB_CYC; k++) if (hist[k][i] == m_deb[i]) all_diff = 1'b0;
          if (all_diff) m_deb[i] = ~m_deb[i];
        end
        s2 = s1;
        s1 = dio_in;
      end
    end
  end

  logic [NUM_CH-1:0] e_out, e_oe, e_done, e_sync;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && checking) begin
        for (int i = 0; i < NUM_CH; i++) begin
          e_out[i] = 1'b0; e_oe[i] = 1'b0; e_done[i] = 1'b0;
          case (ac_mode[i])
            1: e_oe[i] = 1'b1;
            2: begin e_oe[i] = 1'b1; e_out[i] = 1'b1; end
            3: begin e_oe[i] = 1'b1; e_out[i] = ((t_apply / (ac_per[i] + 1)) % 2) == 1; end
            4: begin
              e_oe[i]   = 1'b1;
              e_out[i]  = (t_apply < ac_per[i] + 1);
              e_done[i] = !e_out[i];
            end
            default: ;
          endcase
        end
`ifdef DIO_DEBOUNCE_EN
        e_sync = m_deb;
`else
        e_sync = s2;
`endif
        chk("model_dio_out", dio_out, e_out);
        chk("model_dio_oe", dio_oe, e_oe);
        chk("model_pulse_done", pulse_done, e_done);
        chk("model_dio_in_sync", dio_in_sync, e_sync);
        chk("model_cfg_ready", cfg_ready, m_ready);
        chk("model_cfg_err", cfg_err, m_err);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Tasks start and end on a falling edge.
  task automatic wr(input int ch, input int mode, input int per);
    cfg_ch = CH_W'(ch); cfg_mode = DIO_MODE_W'(mode); cfg_period = DIV_W'(per);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
  endtask

  bit tog2_exp [7]  = '{0, 0, 0, 1, 1, 1, 0};
  bit tog0_exp [4]  = '{0, 1, 0, 1};
  bit pls_out [8]   = '{1, 1, 1, 1, 1, 0, 0, 0};
  bit pls_done [8]  = '{0, 0, 0, 0, 0, 1, 1, 1};
  int lat;
  bit seen;

  initial begin
    rst = 1'b1; cfg_valid = 0; cfg_commit = 0; cfg_ch = '0; cfg_mode = '0;
    cfg_period = '0; dio_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_oe", dio_oe, 0);
    chk("reset_out", dio_out, 0);
    chk("reset_ready", cfg_ready, 0);
    chk("reset_done", pulse_done, 0);
    chk("reset_sync", dio_in_sync, 0);
    rst = 1'b0;
    checking = 1'b1;
    @(negedge clk);
    chk("ready_first_edge", cfg_ready, 1);
    repeat (5) @(negedge clk);
    chk("idle_oe", dio_oe, 0);
    chk("idle_out", dio_out, 0);

    // static modes
    wr(3, DIO_HIGH, 0); wr(5, DIO_LOW, 0); wr(7, DIO_HIZ, 0);
    commit();
    chk("bubble_ready", cfg_ready, 0);
    @(negedge clk);
    chk("bubble_ready_back", cfg_ready, 1);
    chk("ch3_high", {dio_oe[3], dio_out[3]}, 2'b11);
    chk("ch5_low", {dio_oe[5], dio_out[5]}, 2'b10);
    chk("ch7_hiz", dio_oe[7], 0);

    // toggle N=2 then N=0
    wr(0, DIO_TOGGLE, 2);
    commit();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("tog2_out_%0d", k), {dio_oe[0], dio_out[0]}, {1'b1, tog2_exp[k]});
    end
    wr(0, DIO_TOGGLE, 0);
    commit();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("tog0_out_%0d", k), dio_out[0], tog0_exp[k]);
    end

    // pulse N=4, then re-fire with a second commit
    wr(1, DIO_PULSE, 4);
    commit();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("pulse_out_%0d", k), dio_out[1], pls_out[k]);
      chk($sformatf("pulse_done_%0d", k), pulse_done[1], pls_done[k]);
    end
    commit();
    chk("pulse_done_until_apply", pulse_done[1], 1);
    @(negedge clk);
    chk("refire_out", dio_out[1], 1);
    chk("refire_done_clr", pulse_done[1], 0);
    repeat (6) @(negedge clk);
    chk("refire_done_set", pulse_done[1], 1);

    // invalid channel indices
    wr(NUM_CH, DIO_HIGH, 0);
    chk("err_pulse", cfg_err, 1);
    @(negedge clk);
    chk("err_one_cycle", cfg_err, 0);
    wr(31, DIO_PULSE, 9);
    chk("err_pulse_31", cfg_err, 1);

    // write in the same cycle as the commit
    cfg_ch = 5'd2; cfg_mode = DIO_MODE_W'(DIO_HIGH); cfg_period = '0;
    cfg_valid = 1'b1; cfg_commit = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; cfg_commit = 1'b0;
    @(negedge clk);
    chk("same_cycle_ch2", {dio_oe[2], dio_out[2]}, 2'b11);
    chk("err_clear_commit", cfg_err, 0);
    repeat (3) @(negedge clk);

    // asynchronous reset mid-toggle
    #2 rst = 1'b1;
    #1 chk("async_rst_oe", dio_oe, 0);
    chk("async_rst_out", dio_out, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    commit();
    @(negedge clk);
    chk("no_cfg_survives", dio_oe, 0);

    // input synchroniser latency
    dio_in[4] = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (dio_in_sync[4]) lat = k;
    end
    chk("in_sync_latency", lat, IN_LAT);

    // single-cycle glitch on bit 5
    dio_in[5] = 1'b1;
    @(negedge clk);
    dio_in[5] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (dio_in_sync[5]) seen = 1'b1;
    end
    chk("glitch_propagation", seen, GLITCH_SEEN);

    // random pad activity against the model
    for (int k = 0; k < 40; k++) begin
      dio_in = NUM_CH'($urandom);
      if (k % 3 == 0) dio_in = dio_in ^ NUM_CH'($urandom);
      @(negedge clk);
    end
    dio_in = '1;
    repeat (IN_LAT + 2) @(negedge clk);
    chk("in_sync_all_ones", dio_in_sync, {NUM_CH{1'b1}});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
